uart_hex_loader: RTL and testbench

//  Parametrised ASCII-hex program loader between the UART byte interface and a word-wide instruction memory.

---
 rtl/uart_hex_loader_if.sv | 25 ++
 rtl/uart_hex_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_hex_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_loader_if.sv
// rtl/uart_hex_loader_if.sv - UART byte side and instruction-memory write port of the hex loader
interface uart_hex_loader_if #(
  parameter int WORD_W = 32,
  parameter int AW     = 4
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              rx_clr;
  logic              tx_busy;
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  rx_rdy, rx_data, tx_busy,
    output rx_clr, tx_wr, tx_data, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_rdy, rx_data, tx_busy,
    input  rx_clr, tx_wr, tx_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_hex_loader.sv
// rtl/uart_hex_loader.sv - ASCII-hex program loader from UART bytes into instruction memory words
module uart_hex_loader #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter bit ECHO   = 1'b1,
  parameter bit WRAP   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  uart_hex_loader_if.master  bus,
  output logic [AW:0]        word_count,
  output logic               full,
  output logic [7:0]         err_count,
  output logic [WORD_W-1:0]  checksum
);

  localparam int DIGITS = WORD_W / 4;
  localparam int NW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DEC, S_WR, S_ECHO} state_t;

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [NW-1:0]     nib_q, nib_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       wc_d;
  logic              full_d;
  logic [7:0]        err_d, err_inc;
  logic [WORD_W-1:0] chk_d;
  logic              rx_clr_d, tx_wr_d, mem_we_d;
  logic [7:0]        tx_data_d;
  logic [AW-1:0]     mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_d;
  logic              is_hex, is_sep;
  logic [3:0]        nib_val;

  assign err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  // Classify the latched byte: hex digit value (either case) or word separator
  always_comb begin
    is_hex  = 1'b0;
    nib_val = 4'd0;
    is_sep  = (byte_q == 8'h20) || (byte_q == 8'h0D) || (byte_q == 8'h0A) || (byte_q == 8'h2C);
    if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
      is_hex  = 1'b1;
      nib_val = byte_q[3:0];
    end else if ((byte_q >= 8'h41 && byte_q <= 8'h46) || (byte_q >= 8'h61 && byte_q <= 8'h66)) begin
      is_hex  = 1'b1;
      nib_val = byte_q[3:0] + 4'd9;
    end
  end

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    shreg_d     = shreg_q;
    nib_d       = nib_q;
    addr_d      = addr_q;
    wc_d        = word_count;
    full_d      = full;
    err_d       = err_count;
    chk_d       = checksum;
    rx_clr_d    = 1'b0;
    tx_wr_d     = 1'b0;
    mem_we_d    = 1'b0;
    tx_data_d   = bus.tx_data;
    mem_addr_d  = bus.mem_addr;
    mem_wdata_d = bus.mem_wdata;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_rdy) begin
          byte_d   = bus.rx_data;
          rx_clr_d = 1'b1;
          state_d  = S_DEC;
        end
      end
      S_DEC: begin
        state_d = S_ECHO;
        if (load_en) begin
          if (is_hex) begin
            shreg_d = (shreg_q << 4) | WORD_W'(nib_val);
            if (nib_q == NW'(DIGITS - 1)) begin
              nib_d   = '0;
              state_d = S_WR;
            end else begin
              nib_d = nib_q + NW'(1);
            end
          end else if (is_sep) begin
            // A separator between complete words is fine; one inside a word is an error
            if (nib_q != '0) begin
              nib_d = '0;
              err_d = err_inc;
            end
          end else if (byte_q == 8'h23) begin
            addr_d = '0;
            wc_d   = '0;
            full_d = 1'b0;
            chk_d  = '0;
            nib_d  = '0;
          end else begin
            nib_d = '0;
            err_d = err_inc;
          end
        end
      end
      S_WR: begin
        state_d = S_ECHO;
        if (full && !WRAP) begin
          err_d = err_inc;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = shreg_q;
          chk_d       = checksum ^ shreg_q;
          // Compare on AW+1 bits so a non-power-of-two DEPTH still wraps at DEPTH-1
          addr_d      = ({1'b0, addr_q} == (AW + 1)'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
          if (word_count != (AW + 1)'(DEPTH)) wc_d = word_count + (AW + 1)'(1);
          full_d      = (wc_d == (AW + 1)'(DEPTH));
        end
      end
      S_ECHO: begin
        if (!ECHO) begin
          state_d = S_IDLE;
        end else if (!bus.tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = byte_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_q        <= '0;
      shreg_q       <= '0;
      nib_q         <= '0;
      addr_q        <= '0;
      word_count    <= '0;
      full          <= 1'b0;
      err_count     <= '0;
      checksum      <= '0;
      bus.rx_clr    <= 1'b0;
      bus.tx_wr     <= 1'b0;
      bus.tx_data   <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      shreg_q       <= shreg_d;
      nib_q         <= nib_d;
      addr_q        <= addr_d;
      word_count    <= wc_d;
      full          <= full_d;
      err_count     <= err_d;
      checksum      <= chk_d;
      bus.rx_clr    <= rx_clr_d;
      bus.tx_wr     <= tx_wr_d;
      bus.tx_data   <= tx_data_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_loader.sv
// tb/tb_uart_hex_loader.sv - self-checking bench for uart_hex_loader (WRAP=0/ECHO=1 and WRAP=1/ECHO=0)
module tb_uart_hex_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_en = 1'b1;
  logic force_busy = 1'b0;
  int   busy_cnt = 0;

  logic [4:0]  wc0, wc1;
  logic        full0, full1;
  logic [7:0]  err0, err1;
  logic [31:0] chk0, chk1;

  int tests = 0;
  int fails = 0;

  // observed traffic
  logic [35:0] gw0[$], gw1[$];
  logic [7:0]  gt0[$];
  int          gt1n = 0;
  int          rxc0 = 0;

  // reference model state and expectations
  logic [35:0] ew0[$], ew1[$];
  logic [7:0]  et0[$];
  logic [31:0] m_val[2];
  int          m_nib[2], m_addr[2], m_cnt[2], m_err[2];
  logic [31:0] m_chk[2];
  int          pw0 = 0, pw1 = 0, pt0 = 0;

  always #5 clk = ~clk;

  uart_hex_loader_if #(.WORD_W(32), .AW(4)) if0 ();
  uart_hex_loader_if #(.WORD_W(32), .AW(4)) if1 ();

  uart_hex_loader #(.WORD_W(32), .DEPTH(16), .ECHO(1'b1), .WRAP(1'b0)) u0 (
    .clk(clk), .rst(rst), .load_en(load_en), .bus(if0),
    .word_count(wc0), .full(full0), .err_count(err0), .checksum(chk0));

  uart_hex_loader #(.WORD_W(32), .DEPTH(16), .ECHO(1'b0), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .load_en(load_en), .bus(if1),
    .word_count(wc1), .full(full1), .err_count(err1), .checksum(chk1));

  // UART transmitter model: busy rises the cycle after a write and stays up a random while
  assign if0.tx_busy = force_busy | (busy_cnt != 0);
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (if0.tx_wr) busy_cnt <= 1 + int'($urandom_range(0, 3));
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (if0.mem_we) gw0.push_back({if0.mem_addr, if0.mem_wdata});
    if (if1.mem_we) gw1.push_back({if1.mem_addr, if1.mem_wdata});
    if (if0.tx_wr) gt0.push_back(if0.tx_data);
    if (if1.tx_wr) gt1n++;
    if (if0.rx_clr) rxc0++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexchar(input int n, input bit up);
    if (n < 10) return 8'(48 + n);
    return up ? 8'(55 + n) : 8'(87 + n);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = '0; m_nib[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_chk[k] = '0;
    end
  endtask

  task automatic model_err(input int k);
    if (m_err[k] < 255) m_err[k]++;
  endtask

  // Loader behaviour for one byte; instance 0 drops when full and echoes, instance 1 wraps
  task automatic model_byte(input int k, input logic [7:0] b);
    int d;
    d = hexval(b);
    if (k == 0) et0.push_back(b);
    if (!load_en) return;
    if (d >= 0) begin
      m_val[k] = (m_val[k] << 4) | 32'(d);
      m_nib[k]++;
      if (m_nib[k] == 8) begin
        m_nib[k] = 0;
        if (m_cnt[k] == 16 && k == 0) model_err(k);
        else begin
          if (k == 0) ew0.push_back({4'(m_addr[k]), m_val[k]});
          else        ew1.push_back({4'(m_addr[k]), m_val[k]});
          m_chk[k] ^= m_val[k];
          m_addr[k] = (m_addr[k] + 1) % 16;
          if (m_cnt[k] < 16) m_cnt[k]++;
        end
      end
    end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A || b == 8'h2C) begin
      if (m_nib[k] != 0) begin
        m_nib[k] = 0;
        model_err(k);
      end
    end else if (b == 8'h23) begin
      m_addr[k] = 0; m_cnt[k] = 0; m_chk[k] = '0; m_nib[k] = 0;
    end else begin
      m_nib[k] = 0;
      model_err(k);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    model_byte(0, b);
    model_byte(1, b);
    if0.rx_data = b; if1.rx_data = b;
    if0.rx_rdy = 1'b1; if1.rx_rdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (if0.rx_clr) if0.rx_rdy = 1'b0;
      if (if1.rx_clr) if1.rx_rdy = 1'b0;
      done = !if0.rx_rdy && !if1.rx_rdy;
    end
    if (!done) begin
      chk("rx_accept_timeout", 64'(done), 64'd1);
      if0.rx_rdy = 1'b0; if1.rx_rdy = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) send_byte(hexchar(int'(w[i*4 +: 4]), 1'($urandom_range(0, 1))));
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nwr0"}, 64'(gw0.size()), 64'(ew0.size()));
    chk({tag, "_nwr1"}, 64'(gw1.size()), 64'(ew1.size()));
    chk({tag, "_necho0"}, 64'(gt0.size()), 64'(et0.size()));
    for (int i = pw0; i < gw0.size() && i < ew0.size(); i++) chk({tag, "_wr0"}, 64'(gw0[i]), 64'(ew0[i]));
    for (int i = pw1; i < gw1.size() && i < ew1.size(); i++) chk({tag, "_wr1"}, 64'(gw1[i]), 64'(ew1[i]));
    for (int i = pt0; i < gt0.size() && i < et0.size(); i++) chk({tag, "_echo0"}, 64'(gt0[i]), 64'(et0[i]));
    pw0 = gw0.size(); pw1 = gw1.size(); pt0 = gt0.size();
    chk({tag, "_tx1"}, 64'(gt1n), 64'd0);
    chk({tag, "_wc0"}, 64'(wc0), 64'(m_cnt[0]));
    chk({tag, "_wc1"}, 64'(wc1), 64'(m_cnt[1]));
    chk({tag, "_full0"}, 64'(full0), 64'(m_cnt[0] == 16));
    chk({tag, "_full1"}, 64'(full1), 64'(m_cnt[1] == 16));
    chk({tag, "_err0"}, 64'(err0), 64'(m_err[0]));
    chk({tag, "_err1"}, 64'(err1), 64'(m_err[1]));
    chk({tag, "_chk0"}, 64'(chk0), 64'(m_chk[0]));
    chk({tag, "_chk1"}, 64'(chk1), 64'(m_chk[1]));
  endtask

  initial begin
    int n0, r0, r;
    logic [7:0] junk[5];
    junk[0] = "G"; junk[1] = "x"; junk[2] = "!"; junk[3] = 8'hFF; junk[4] = "Z";
    if0.rx_rdy = 1'b0; if0.rx_data = '0;
    if1.rx_rdy = 1'b0; if1.rx_data = '0; if1.tx_busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wc", 64'(wc0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_chk", 64'(chk0), 64'd0);
    chk("rst_memwe", 64'(if0.mem_we), 64'd0);

    // T1
    send_str("DEADBEEF"); drain();
    chk("t1_chk_const", 64'(chk0), 64'hDEADBEEF);
    chk("t1_last_wr", 64'(gw0[gw0.size()-1]), {28'd0, 36'h0DEADBEEF});
    compare_all("t1");

    // T2
    do_reset();
    send_str("deadbeef 00000001\n"); drain();
    chk("t2_chk_const", 64'(chk0), 64'hDEADBEEE);
    compare_all("t2");

    // T3
    do_reset();
    send_str("12G5678ABCD"); drain();
    chk("t3_err_const", 64'(err0), 64'd1);
    chk("t3_wr_const", 64'(gw0[gw0.size()-1]), {28'd0, 36'h05678ABCD});
    compare_all("t3");

    // T4 / T5: seventeen words into a 16-deep memory
    do_reset();
    for (int w = 0; w < 17; w++) begin
      send_word($urandom);
      send_byte(8'h20);
    end
    drain();
    chk("t4_full0", 64'(full0), 64'd1);
    chk("t4_err0", 64'(err0), 64'd1);
    chk("t5_full1", 64'(full1), 64'd1);
    chk("t5_last_addr1", 64'(gw1[gw1.size()-1][35:32]), 64'd0);
    compare_all("t45");
    send_str("#"); send_word(32'h0BADF00D); drain();
    chk("t4_rewind_wc", 64'(wc0), 64'd1);
    chk("t4_rewind_wr", 64'(gw0[gw0.size()-1]), {28'd0, 36'h00BADF00D});
    compare_all("t4r");

    // T6: echo held off by a busy transmitter
    force_busy = 1'b1;
    n0 = gt0.size(); r0 = rxc0;
    send_byte("7");
    repeat (50) @(posedge clk);
    #1;
    chk("t6_no_echo_while_busy", 64'(gt0.size()), 64'(n0));
    chk("t6_one_rx_clr", 64'(rxc0 - r0), 64'd1);
    force_busy = 1'b0;
    drain();
    chk("t6_echo_after", 64'(gt0.size()), 64'(n0 + 1));
    compare_all("t6");

    // Reset mid-word
    send_str("1234"); drain();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_wc", 64'(wc0), 64'd0);
    chk("rstmid_full", 64'(full0), 64'd0);
    chk("rstmid_err", 64'(err0), 64'd0);
    chk("rstmid_chk", 64'(chk0), 64'd0);
    chk("rstmid_outs", {if0.mem_we, if0.mem_addr, if0.mem_wdata, if0.tx_wr, if0.tx_data, if0.rx_clr}, 64'd0);
    rst = 1'b0;
    model_reset();
    send_str("5678"); drain();
    compare_all("rstmid");

    // Randomized byte streams with load_en toggling
    for (int blk = 0; blk < 8; blk++) begin
      load_en = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < 40; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 70) send_byte(hexchar(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));
        else if (r < 85) begin
          case ($urandom_range(0, 3))
            0: send_byte(8'h20);
            1: send_byte(8'h0D);
            2: send_byte(8'h0A);
            default: send_byte(8'h2C);
          endcase
        end else if (r < 88) send_byte(8'h23);
        else send_byte(junk[$urandom_range(0, 4)]);
      end
      drain();
      compare_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
